seq_step_ctrl: RTL and testbench
================================

Name: seq_step_ctrl

Overview:
- Advance/clear controller for the 3-bit self-starting sequence counters (1-2-7-3-6-1 family) on the board.
- Converts raw pushbuttons into clean single-cycle ADV (advance-enable) and CLR (force-to-1) pulses.
- Supports manual single-step and auto-run at a prescaled rate.
- The counter then runs on the system clock gated by ADV, instead of being clocked directly by KEY[0].

Parameters:
- DEB_CYCLES, 500000, consecutive stable cycles required before a debounced key level changes (10 ms at 50 MHz).
- RUN_DIV, 50000000, clock cycles between ADV pulses in auto-run (1 Hz at 50 MHz); must be >= 2.

Ports:
- CLK  input  1  system clock, all logic on the rising edge
- RST_N  input  1  asynchronous active-low reset
- KEY_STEP  input  1  raw active-low step button, asynchronous to CLK
- KEY_RUN  input  1  raw active-low run/stop toggle button, asynchronous
- KEY_CLR  input  1  raw active-low clear button, asynchronous
- ADV  output  1  one-cycle advance-enable pulse to the sequence counter
- CLR  output  1  one-cycle pulse forcing the sequence counter to 1
- RUNNING  output  1  high while in the RUN state (LED)

Behaviour:
Reset:
- RST_N low forces: state STOP, ADV=0, CLR=0, RUNNING=0.
- All synchronizer flops and debounced levels reset to 1 (released); debounce and prescale counters reset to 0.
- Reset asserted mid-debounce or mid-prescale discards all progress.

Input conditioning (per key):
- 2-flop synchronizer, then debouncer.
- Debounce counter increments each cycle the synced input differs from the debounced level, and clears when they match.
- When the counter reaches DEB_CYCLES-1 while still differing, the debounced level flips and the counter clears.
- Press event: one-cycle pulse on a debounced 1->0 transition. Release produces no event.
- Timing: raw key held low from cycle 0 gives synced low at cycle 2, debounced low at cycle 2+DEB_CYCLES-1, press event in that same cycle. The registered ADV/CLR/state change is visible in cycle 2+DEB_CYCLES.
- Glitches shorter than DEB_CYCLES cycles produce no event.

FSM (2 states, registered outputs):
- STOP:
  - run_ev -> RUN, prescaler cleared to 0.
  - step_ev (without run_ev) -> one ADV pulse; stay in STOP.
- RUN:
  - Prescaler counts 0..RUN_DIV-1. At RUN_DIV-1: ADV pulse, wrap to 0.
  - run_ev -> STOP, prescaler cleared, no ADV pulse that cycle.
  - step_ev is ignored.
- First ADV after entering RUN comes exactly RUN_DIV cycles after RUNNING rises; consecutive ADVs are RUN_DIV cycles apart.
- RUNNING = (state == RUN), registered.

Clear and priority rules:
- clr_ev: CLR pulse and prescaler cleared. State is unchanged unless run_ev arrives in the same cycle, in which case the toggle is also applied.
- Same-cycle priority: CLR suppresses ADV (clr_ev with step_ev or with a prescale terminal count gives CLR=1, ADV=0). run_ev beats step_ev.
- ADV and CLR are never high in the same cycle.
- Holding a key produces exactly one event per press.

Decomposition:
- Package seq_ctrl_pkg:
  - typedef enum logic {ST_STOP, ST_RUN} ctrl_state_t
  - default constants DEB_CYCLES_DEF and RUN_DIV_DEF
  - SIM_DEB_CYCLES=4 and SIM_RUN_DIV=8 for benches
- Counter widths derived with $clog2 inside the module.
- Sub-module key_debounce (parameter DEB_CYCLES; ports CLK, RST_N, KEY_RAW, LEVEL, PRESS), instantiated three times.

Test Plan (DEB_CYCLES=4, RUN_DIV=8):
1. Reset release with all keys high, run 50 cycles -> ADV=0, CLR=0, RUNNING=0 throughout.
2. KEY_STEP low from cycle 0 and held 20 cycles -> single ADV pulse in cycle 6 only, RUNNING stays 0. Repeat with a 3-cycle low glitch -> no ADV.
3. KEY_RUN press -> RUNNING rises in cycle 6; ADV at cycles 14, 22, 30. Second KEY_RUN press -> RUNNING falls and no further ADV.
4. In RUN, KEY_CLR press timed so its event coincides with prescaler terminal count -> CLR=1, ADV=0 that cycle; next ADV 8 cycles later; RUNNING unchanged.
5. In STOP, KEY_RUN and KEY_STEP pressed on the same cycle -> RUNNING=1, no ADV pulse from the step.
6. RST_N asserted mid-RUN at an asynchronous point -> outputs 0 immediately. After release, no ADV until a new press.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the sequence-counter advance/clear controller.
package seq_ctrl_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  localparam int unsigned DEB_CYCLES_DEF = 500000;
  localparam int unsigned RUN_DIV_DEF    = 50000000;

  localparam int unsigned SIM_DEB_CYCLES = 4;
  localparam int unsigned SIM_RUN_DIV    = 8;

  // Bits needed for a counter spanning 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low pushbutton; PRESS is a one-cycle
// pulse on the debounced 1->0 transition.
module key_debounce
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic KEY_RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam int unsigned CNT_W = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= KEY_RAW;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Level flips only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign LEVEL = level_q;
  assign PRESS = level_q & ~level_d;

endmodule

// File: rtl/seq_step_ctrl.sv
// Turns step/run/clear pushbuttons into single-cycle ADV and CLR pulses for
// the sequence counter, with manual stepping and prescaled auto-run.
module seq_step_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned RUN_DIV    = RUN_DIV_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic KEY_STEP,
  input  logic KEY_RUN,
  input  logic KEY_CLR,
  output logic ADV,
  output logic CLR,
  output logic RUNNING
);

  localparam int unsigned PRE_W = cnt_width(RUN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RUN_DIV - 1);

  logic [2:0]  unused_level;
  logic        step_ev;
  logic        run_ev;
  logic        clr_ev;

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] presc_d;
  logic        adv_q;
  logic        adv_d;
  logic        clr_q;
  logic        clr_d;
  logic        running_q;
  logic        running_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .KEY_RAW (KEY_STEP),
    .LEVEL   (unused_level[0]),
    .PRESS   (step_ev)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .KEY_RAW (KEY_RUN),
    .LEVEL   (unused_level[1]),
    .PRESS   (run_ev)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .KEY_RAW (KEY_CLR),
    .LEVEL   (unused_level[2]),
    .PRESS   (clr_ev)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      adv_q     <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      adv_q     <= adv_d;
      clr_q     <= clr_d;
      running_q <= running_d;
    end
  end

  // run_ev beats step_ev; clr_ev overrides any ADV and restarts the prescaler.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    adv_d   = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        if (run_ev) begin
          state_d = ST_RUN;
          presc_d = '0;
        end else if (step_ev) begin
          adv_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_ev) begin
          state_d = ST_STOP;
          presc_d = '0;
        end else if (presc_q == PRE_LAST) begin
          adv_d   = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
        presc_d = '0;
      end
    endcase
    if (clr_ev) begin
      clr_d   = 1'b1;
      adv_d   = 1'b0;
      presc_d = '0;
    end
    running_d = (state_d == ST_RUN);
  end

  assign ADV     = adv_q;
  assign CLR     = clr_q;
  assign RUNNING = running_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Scoreboard bench for seq_step_ctrl: a cycle-level reference model predicts
// ADV/CLR/RUNNING from the raw key history; a monitor compares every cycle.
module tb_seq_step_ctrl;
  import seq_ctrl_pkg::*;

  localparam int unsigned DEB  = SIM_DEB_CYCLES;
  localparam int unsigned RDIV = SIM_RUN_DIV;

  typedef struct packed {
    logic adv;
    logic clr;
    logic run;
  } obs_t;

  logic CLK;
  logic RST_N;
  logic KEY_STEP;
  logic KEY_RUN;
  logic KEY_CLR;
  logic ADV;
  logic CLR;
  logic RUNNING;

  obs_t       exp_q[$];
  logic [2:0] hist[$];
  logic [2:0] m_lvl;
  bit         m_running;
  int         m_next_adv;
  int         edge_n;
  int         vectors;
  int         miscompares;
  int         adv_seen;
  int         clr_seen;

  seq_step_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(RDIV)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .KEY_STEP (KEY_STEP),
    .KEY_RUN  (KEY_RUN),
    .KEY_CLR  (KEY_CLR),
    .ADV      (ADV),
    .CLR      (CLR),
    .RUNNING  (RUNNING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(DEB) + 2; i++) hist.push_back(3'b111);
    m_lvl      = 3'b111;
    m_running  = 1'b0;
    m_next_adv = 0;
  endtask

  // Reference model: a key's debounced level flips when the last DEB
  // synchronized samples (raw delayed two edges) all differ from it.
  initial begin
    obs_t       e;
    logic [2:0] ev;
    bit         all_diff;
    edge_n = 0;
    model_reset();
    forever begin
      @(posedge CLK);
      edge_n++;
      e = '0;
      if (!RST_N) begin
        model_reset();
      end else begin
        hist.push_back({KEY_CLR, KEY_RUN, KEY_STEP});
        if (hist.size() > int'(DEB) + 2) void'(hist.pop_front());
        ev = 3'b000;
        for (int k = 0; k < 3; k++) begin
          all_diff = 1'b1;
          for (int j = 2; j <= int'(DEB) + 1; j++) begin
            if (hist[hist.size() - 1 - j][k] == m_lvl[k]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_lvl[k] = ~m_lvl[k];
            if (m_lvl[k] == 1'b0) ev[k] = 1'b1;
          end
        end
        if (ev[1]) begin
          m_running  = !m_running;
          m_next_adv = edge_n + int'(RDIV);
        end else if (!m_running) begin
          if (ev[0]) e.adv = 1'b1;
        end else if (edge_n == m_next_adv) begin
          e.adv      = 1'b1;
          m_next_adv = m_next_adv + int'(RDIV);
        end
        if (ev[2]) begin
          e.clr      = 1'b1;
          e.adv      = 1'b0;
          m_next_adv = edge_n + int'(RDIV);
        end
        e.run = m_running;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected record per clock, compared mid-cycle.
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {ADV, CLR, RUNNING};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: adv/clr/run got %b%b%b required %b%b%b",
                   edge_n, got.adv, got.clr, got.run, e.adv, e.clr, e.run);
        end
        if (ADV === 1'b1) adv_seen++;
        if (CLR === 1'b1) clr_seen++;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic async_reset(input int hold);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("rst_adv", int'(ADV), 0);
    check("rst_clr", int'(CLR), 0);
    check("rst_running", int'(RUNNING), 0);
    repeat (hold) @(posedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    tick(1);
  endtask

  initial begin
    int  base_adv;
    int  base_clr;
    bit  hit;
    vectors     = 0;
    miscompares = 0;
    adv_seen    = 0;
    clr_seen    = 0;
    RST_N       = 1'b0;
    KEY_STEP    = 1'b1;
    KEY_RUN     = 1'b1;
    KEY_CLR     = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    tick(1);

    // Idle after reset.
    base_adv = adv_seen;
    base_clr = clr_seen;
    tick(50);
    check("idle_adv", adv_seen - base_adv, 0);
    check("idle_clr", clr_seen - base_clr, 0);
    check("idle_running", int'(RUNNING), 0);

    // Held step key gives exactly one ADV; a short glitch gives none.
    base_adv = adv_seen;
    KEY_STEP = 1'b0;
    tick(20);
    KEY_STEP = 1'b1;
    tick(10);
    check("step_once", adv_seen - base_adv, 1);
    check("step_running", int'(RUNNING), 0);
    base_adv = adv_seen;
    KEY_STEP = 1'b0;
    tick(int'(DEB) - 1);
    KEY_STEP = 1'b1;
    tick(12);
    check("glitch_none", adv_seen - base_adv, 0);

    // Auto-run for a few periods, then stop.
    KEY_RUN = 1'b0;
    tick(10);
    KEY_RUN = 1'b1;
    tick(26);
    check("run_running", int'(RUNNING), 1);
    check("run_adv_count", adv_seen - base_adv, 3);
    KEY_RUN = 1'b0;
    tick(10);
    KEY_RUN = 1'b1;
    tick(2);
    check("stop_running", int'(RUNNING), 0);
    base_adv = adv_seen;
    tick(30);
    check("stop_no_adv", adv_seen - base_adv, 0);

    // Clear event landing on the prescaler terminal count.
    KEY_RUN = 1'b0;
    tick(10);
    KEY_RUN = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (m_running && (m_next_adv - edge_n == int'(DEB) + 2)) hit = 1'b1;
      else tick(1);
    end
    check("clr_align_found", int'(hit), 1);
    KEY_CLR = 1'b0;
    tick(int'(DEB) + 2);
    check("clr_tc_clr", int'(CLR), 1);
    check("clr_tc_adv", int'(ADV), 0);
    check("clr_tc_running", int'(RUNNING), 1);
    tick(int'(RDIV));
    check("clr_next_adv", int'(ADV), 1);
    KEY_CLR = 1'b1;
    tick(5);
    KEY_RUN = 1'b0;
    tick(10);
    KEY_RUN = 1'b1;
    tick(5);
    check("clr_then_stop", int'(RUNNING), 0);

    // Run and step together from STOP: run wins, no step ADV.
    base_adv = adv_seen;
    KEY_RUN  = 1'b0;
    KEY_STEP = 1'b0;
    tick(int'(DEB) + 5);
    check("runstep_running", int'(RUNNING), 1);
    check("runstep_no_adv", adv_seen - base_adv, 0);
    KEY_RUN  = 1'b1;
    KEY_STEP = 1'b1;

    // Asynchronous reset mid-run; nothing happens until a new press.
    tick(11);
    async_reset(3);
    base_adv = adv_seen;
    tick(40);
    check("post_rst_no_adv", adv_seen - base_adv, 0);
    check("post_rst_running", int'(RUNNING), 0);

    // Random key activity: mixture of glitches and real presses.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) KEY_STEP = ~KEY_STEP;
      if ($urandom_range(0, 7) == 0) KEY_RUN  = ~KEY_RUN;
      if ($urandom_range(0, 9) == 0) KEY_CLR  = ~KEY_CLR;
      if (c == 1500) async_reset(2);
      else tick(1);
    end
    KEY_STEP = 1'b1;
    KEY_RUN  = 1'b1;
    KEY_CLR  = 1'b1;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
